// File: rtl/axis_rr_arb_if.sv
// Bundle of the arbiter's AXI-Stream buses: NUM_CH slave channels merged onto
// one master stream. The master modport is the arbiter's view; the slave
// modport is the surrounding environment (upstream sources and the downstream
// sink).
interface axis_rr_arb_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Slave side: channel i owns bit i and data bits [i*DATA_W +: DATA_W]
    logic [NUM_CH-1:0]        s_axis_tvalid;
    logic [NUM_CH-1:0]        s_axis_tready;
    logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
    logic [NUM_CH-1:0]        s_axis_tlast;

    // Merged master side; tid names the source channel of the current beat
    logic                     m_axis_tvalid;
    logic                     m_axis_tready;
    logic [DATA_W-1:0]        m_axis_tdata;
    logic                     m_axis_tlast;
    logic [CH_W-1:0]          m_axis_tid;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid
    );
endinterface

// File: rtl/axis_rr_arb.sv
// Packet-level round-robin arbiter for NUM_CH AXI-Stream channels.
// In IDLE one cycle is spent choosing the next requesting channel after the
// previous winner. The winner then holds the grant (LOCK) until its tlast beat
// is accepted. Beats pass through a single output register, so data appears one
// cycle after acceptance, and a packet can stream at one beat per cycle.
module axis_rr_arb #(
    parameter int NUM_CH = 4,   // 2..16; must match the interface instance
    parameter int DATA_W = 8    // multiple of 8, 8..512
) (
    input logic           aclk,
    input logic           aresetn,
    axis_rr_arb_if.master axis
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW1  = CH_W + 1;

    localparam logic [CW1-1:0]  NUM_CH_X = CW1'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    // Arbitration state
    logic [0:0]        state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;

    // One-beat output register
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [CH_W-1:0]   out_tid_q, out_tid_d;

    // Arbitration and handshake helpers
    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [CW1-1:0]      start;
    logic [CW1-1:0]      cand;
    logic [CH_W-1:0]     pick;
    logic                req_any;
    logic                ready_ok;
    logic                accept;
    logic [NUM_CH-1:0]   s_ready;
    logic [DATA_W-1:0]   beat_data;
    logic                beat_last;

    // Round-robin pick: rotate the requests so the channel after last_grant
    // lands at bit 0, then take the lowest set bit and map it back.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch, so
        // no path leaves one unassigned and no latch is inferred.
        req_dbl = {axis.s_axis_tvalid, axis.s_axis_tvalid};
        start   = {1'b0, last_grant_q} + CW1'(1);
        req_rot = req_dbl[start +: NUM_CH];
        req_any = |axis.s_axis_tvalid;
        pick    = grant_q;
        cand    = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                cand = start + CW1'(j);
                if (cand >= NUM_CH_X) begin
                    cand = cand - NUM_CH_X;
                end
                pick = cand[CH_W-1:0];
            end
        end
    end

    // Slave handshake: only the granted channel sees ready, and only while
    // the output register is empty or being drained this cycle.
    always_comb begin
        ready_ok  = !out_valid_q || axis.m_axis_tready;
        accept    = (state_q == ST_LOCK) && axis.s_axis_tvalid[grant_q] && ready_ok;
        s_ready   = '0;
        if ((state_q == ST_LOCK) && ready_ok) begin
            s_ready = NUM_CH'(1) << grant_q;
        end
        beat_data = axis.s_axis_tdata[grant_q*DATA_W +: DATA_W];
        beat_last = axis.s_axis_tlast[grant_q];
    end

    // IDLE/LOCK sequencing: grant on any request, release on the tlast beat.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    grant_d = pick;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (accept && beat_last) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register: load on an accepted beat, empty once the sink takes it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_tid_d   = out_tid_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_data;
            out_last_d  = beat_last;
            out_tid_d   = grant_q;
        end else if (out_valid_q && axis.m_axis_tready) begin
            out_valid_d = 1'b0;
        end
    end

    // Arbitration state registers; reset gives channel 0 first priority.
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_CH;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Output register; reset discards any pending beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_tid_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_tid_q   <= out_tid_d;
        end
    end

    assign axis.s_axis_tready = s_ready;
    assign axis.m_axis_tvalid = out_valid_q;
    assign axis.m_axis_tdata  = out_data_q;
    assign axis.m_axis_tlast  = out_last_q;
    assign axis.m_axis_tid    = out_tid_q;

endmodule

// File: tb/tb_axis_rr_arb.sv
// Bench for axis_rr_arb (NUM_CH=4, DATA_W=8). Inputs change on the falling
// edge; outputs are sampled 1 time unit before the next rising edge.
module tb_axis_rr_arb;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;

    logic aclk;
    logic aresetn;

    axis_rr_arb_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    axis_rr_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axis    (bus)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [3:0] vld, input logic [31:0] data,
                          input logic [3:0] last, input logic mrdy);
        bus.s_axis_tvalid = vld;
        bus.s_axis_tdata  = data;
        bus.s_axis_tlast  = last;
        bus.m_axis_tready = mrdy;
    endtask

    task automatic check_out(input string tag, input logic [3:0] srdy, input logic mvld,
                             input logic [7:0] data, input logic last, input logic [1:0] tid);
        check({tag, ".s_tready"}, 32'(bus.s_axis_tready), 32'(srdy));
        check({tag, ".m_tvalid"}, 32'(bus.m_axis_tvalid), 32'(mvld));
        if (mvld) begin
            check({tag, ".m_tdata"}, 32'(bus.m_axis_tdata), 32'(data));
            check({tag, ".m_tlast"}, 32'(bus.m_axis_tlast), 32'(last));
            check({tag, ".m_tid"},   32'(bus.m_axis_tid),   32'(tid));
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]  vld;
        logic [31:0] data;
        logic [3:0]  last;
        logic        mrdy;
        logic [3:0]  exp_srdy;
        logic        exp_mvld;
        logic [7:0]  exp_data;
        logic        exp_last;
        logic [1:0]  exp_tid;
    } vec_t;

    vec_t vecs[16];

    // ------------------------------------------------------------------
    // Stream model for round-robin and random traffic
    // ------------------------------------------------------------------
    int fixed_len;
    int src_beat[NUM_CH], src_pos[NUM_CH], src_pkt[NUM_CH];
    int snk_beat[NUM_CH], snk_pos[NUM_CH], snk_pkt[NUM_CH];
    logic       in_pkt;
    logic [1:0] cur_tid;

    function automatic int pkt_len(input int ch, input int pkt);
        if (fixed_len > 0) return fixed_len;
        return 1 + ((ch * 3 + pkt * 5) % 4);
    endfunction

    function automatic logic [7:0] beat_val(input int ch, input int beat);
        return 8'((ch << 6) | (beat & 63));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            src_beat[i] = 0; src_pos[i] = 0; src_pkt[i] = 0;
            snk_beat[i] = 0; snk_pos[i] = 0; snk_pkt[i] = 0;
        end
        in_pkt  = 1'b0;
        cur_tid = '0;
    endtask

    task automatic drive_sources(input logic [3:0] en, input logic mrdy);
        for (int i = 0; i < NUM_CH; i++) begin
            bus.s_axis_tvalid[i]          = en[i];
            bus.s_axis_tdata[i*DATA_W +: DATA_W] = beat_val(i, src_beat[i]);
            bus.s_axis_tlast[i]           = (src_pos[i] == pkt_len(i, src_pkt[i]) - 1);
        end
        bus.m_axis_tready = mrdy;
    endtask

    // Called just before an edge: retire source beats that are handshaking.
    task automatic advance_sources();
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.s_axis_tvalid[i] && bus.s_axis_tready[i]) begin
                src_beat[i]++;
                if (src_pos[i] == pkt_len(i, src_pkt[i]) - 1) begin
                    src_pos[i] = 0;
                    src_pkt[i]++;
                end else begin
                    src_pos[i]++;
                end
            end
        end
    endtask

    // Called for each beat the sink takes: compare against the model.
    task automatic sink_beat();
        int t;
        logic exp_last;
        t = int'(bus.m_axis_tid);
        exp_last = (snk_pos[t] == pkt_len(t, snk_pkt[t]) - 1);
        if (in_pkt) check("sb.contiguous_tid", 32'(bus.m_axis_tid), 32'(cur_tid));
        check("sb.tdata", 32'(bus.m_axis_tdata), 32'(beat_val(t, snk_beat[t])));
        check("sb.tlast", 32'(bus.m_axis_tlast), 32'(exp_last));
        cur_tid = bus.m_axis_tid;
        in_pkt  = !bus.m_axis_tlast;
        snk_beat[t]++;
        if (bus.m_axis_tlast) begin
            snk_pos[t] = 0;
            snk_pkt[t]++;
        end else begin
            snk_pos[t]++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge aclk);
        set_in(4'b0000, 32'h0, 4'b0000, 1'b1);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    int first_tid[6];
    int first_cyc[6];
    int n_first;

    initial begin
        // ch0 and ch2 3-beat packets, then ch3 single beat vs ch0
        vecs[0]  = '{4'b0101, 32'h0020_0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[1]  = '{4'b0101, 32'h0020_0010, 4'b0000, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[2]  = '{4'b0101, 32'h0020_0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 8'h10, 1'b0, 2'd0};
        vecs[3]  = '{4'b0101, 32'h0020_0012, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11, 1'b0, 2'd0};
        vecs[4]  = '{4'b0100, 32'h0020_0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h12, 1'b1, 2'd0};
        vecs[5]  = '{4'b0100, 32'h0020_0000, 4'b0000, 1'b1, 4'b0100, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[6]  = '{4'b0100, 32'h0021_0000, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'h20, 1'b0, 2'd2};
        vecs[7]  = '{4'b0100, 32'h0022_0000, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h21, 1'b0, 2'd2};
        vecs[8]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h22, 1'b1, 2'd2};
        vecs[9]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[10] = '{4'b1001, 32'hAB00_0030, 4'b1001, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[11] = '{4'b1001, 32'hAB00_0030, 4'b1001, 1'b1, 4'b1000, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[12] = '{4'b0001, 32'h0000_0030, 4'b0001, 1'b1, 4'b0000, 1'b1, 8'hAB, 1'b1, 2'd3};
        vecs[13] = '{4'b0001, 32'h0000_0030, 4'b0001, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[14] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h30, 1'b1, 2'd0};
        vecs[15] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};

        fixed_len = 0;
        model_reset();

        // Reset state
        aresetn = 1'b0;
        set_in(4'b0101, 32'h0020_0010, 4'b0000, 1'b1);
        repeat (2) @(negedge aclk);
        #4;
        check_out("reset", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        check("reset.m_tdata", 32'(bus.m_axis_tdata), 32'h0);
        check("reset.m_tid",   32'(bus.m_axis_tid),   32'h0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge aclk);
            set_in(vecs[i].vld, vecs[i].data, vecs[i].last, vecs[i].mrdy);
            #4;
            check_out($sformatf("vec%0d", i), vecs[i].exp_srdy, vecs[i].exp_mvld,
                      vecs[i].exp_data, vecs[i].exp_last, vecs[i].exp_tid);
        end

        // ch1 packet with the sink stalled for 5 cycles mid-packet
        @(negedge aclk);
        set_in(4'b0010, 32'h0000_4000, 4'b0000, 1'b1);
        #4; check_out("stall.idle", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        @(negedge aclk);
        #4; check_out("stall.grant", 4'b0010, 1'b0, 8'h00, 1'b0, 2'd0);
        @(negedge aclk);
        set_in(4'b0010, 32'h0000_4100, 4'b0000, 1'b0);
        #4; check_out("stall.c0", 4'b0000, 1'b1, 8'h40, 1'b0, 2'd1);
        for (int c = 1; c < 5; c++) begin
            @(negedge aclk);
            #4; check_out($sformatf("stall.c%0d", c), 4'b0000, 1'b1, 8'h40, 1'b0, 2'd1);
        end
        @(negedge aclk);
        bus.m_axis_tready = 1'b1;
        #4; check_out("stall.release", 4'b0010, 1'b1, 8'h40, 1'b0, 2'd1);
        @(negedge aclk);
        set_in(4'b0010, 32'h0000_4200, 4'b0010, 1'b1);
        #4; check_out("stall.beat1", 4'b0010, 1'b1, 8'h41, 1'b0, 2'd1);
        @(negedge aclk);
        set_in(4'b0000, 32'h0, 4'b0000, 1'b1);
        #4; check_out("stall.beat2", 4'b0000, 1'b1, 8'h42, 1'b1, 2'd1);
        @(negedge aclk);
        #4; check_out("stall.drained", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);

        // Reset during beat 2 of a 4-beat ch2 packet
        @(negedge aclk);
        set_in(4'b0100, 32'h0050_0000, 4'b0000, 1'b1);
        @(negedge aclk);
        #4; check_out("rst.grant", 4'b0100, 1'b0, 8'h00, 1'b0, 2'd0);
        @(negedge aclk);
        set_in(4'b0100, 32'h0051_0000, 4'b0000, 1'b1);
        #4; check_out("rst.beat0", 4'b0100, 1'b1, 8'h50, 1'b0, 2'd2);
        @(negedge aclk);
        set_in(4'b0100, 32'h0052_0000, 4'b0000, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        check("rst.now.m_tvalid", 32'(bus.m_axis_tvalid), 32'h0);
        check("rst.now.m_tdata",  32'(bus.m_axis_tdata),  32'h0);
        check("rst.now.m_tlast",  32'(bus.m_axis_tlast),  32'h0);
        check("rst.now.m_tid",    32'(bus.m_axis_tid),    32'h0);
        check("rst.now.s_tready", 32'(bus.s_axis_tready), 32'h0);
        @(negedge aclk);
        set_in(4'b0101, 32'h0070_0060, 4'b0001, 1'b1);
        #4; check_out("rst.held", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #4; check_out("rst.released", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        @(negedge aclk);
        #4; check_out("rst.first_grant", 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0);
        @(negedge aclk);
        set_in(4'b0000, 32'h0, 4'b0000, 1'b1);
        #4; check_out("rst.first_beat", 4'b0000, 1'b1, 8'h60, 1'b1, 2'd0);
        repeat (2) @(negedge aclk);
        #4; check_out("rst.idle", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);

        // All four channels sending 2-beat packets back to back
        pulse_reset();
        fixed_len = 2;
        model_reset();
        n_first = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge aclk);
            drive_sources(4'b1111, 1'b1);
            #4;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (!in_pkt && n_first < 6) begin
                    first_tid[n_first] = int'(bus.m_axis_tid);
                    first_cyc[n_first] = cyc;
                    n_first++;
                end
                sink_beat();
            end
            advance_sources();
        end
        check("rr.packets_seen", 32'(n_first), 32'd6);
        for (int k = 0; k < n_first; k++) begin
            check($sformatf("rr.order%0d", k), 32'(first_tid[k]), 32'(k % 4));
            if (k > 0) check($sformatf("rr.gap%0d", k), 32'(first_cyc[k] - first_cyc[k-1]), 32'd3);
        end

        // Random valid/ready traffic with scoreboard
        @(negedge aclk);
        drive_sources(4'b0000, 1'b1);
        repeat (3) @(negedge aclk);
        pulse_reset();
        fixed_len = 0;
        model_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic [3:0] en;
            if (cyc > 0) @(negedge aclk);
            for (int i = 0; i < NUM_CH; i++) en[i] = ($urandom_range(0, 3) != 0);
            drive_sources(en, $urandom_range(0, 3) != 0);
            #4;
            check("rand.tready_onehot0", 32'($onehot0(bus.s_axis_tready)), 32'd1);
            if (bus.m_axis_tvalid && bus.m_axis_tready) sink_beat();
            advance_sources();
        end
        // Finish only packets already in progress, then let the output drain
        for (int cyc = 0; cyc < 60; cyc++) begin
            logic [3:0] en;
            @(negedge aclk);
            for (int i = 0; i < NUM_CH; i++) en[i] = (src_pos[i] != 0);
            drive_sources(en, 1'b1);
            #4;
            if (bus.m_axis_tvalid && bus.m_axis_tready) sink_beat();
            advance_sources();
        end
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("rand.beats_ch%0d", i), 32'(snk_beat[i]), 32'(src_beat[i]));
        end
        check("rand.some_traffic", 32'(snk_beat[0] > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
